// File: rtl/msg_sched_pkg.sv
// rtl/msg_sched_pkg.sv - shared types, sigma rotate/shift constants and round-count helper
// Contents:
//   state_e          scheduler state {IDLE, RUN}
//   S*_R*/S*_SH_*    rotate/shift amounts for sigma0/sigma1, 32- and 64-bit words
//   rounds_for()     number of schedule words for a given word width
package msg_sched_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // SHA-224/256 (32-bit words)
   localparam int S0_R1_32 = 7;
   localparam int S0_R2_32 = 18;
   localparam int S0_SH_32 = 3;
   localparam int S1_R1_32 = 17;
   localparam int S1_R2_32 = 19;
   localparam int S1_SH_32 = 10;

   // SHA-384/512 (64-bit words)
   localparam int S0_R1_64 = 1;
   localparam int S0_R2_64 = 8;
   localparam int S0_SH_64 = 7;
   localparam int S1_R1_64 = 19;
   localparam int S1_R2_64 = 61;
   localparam int S1_SH_64 = 6;

   function automatic int rounds_for(input int word_w);
      return (word_w == 64) ? 80 : 64;
   endfunction

endpackage

// File: rtl/msg_sched_sigma.sv
// rtl/msg_sched_sigma.sv - combinational SHA-2 small sigma function (sigma0 or sigma1)
// Parameters:
//   WORD_W  word width, 32 or 64
//   SEL     0 selects sigma0, 1 selects sigma1
// Ports:
//   i_x     input word
//   o_y     ROTR(a) ^ ROTR(b) ^ SHR(c) of i_x
module msg_sigma
   import msg_sched_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter bit SEL    = 1'b0
)
(
   input  logic [WORD_W-1:0] i_x,
   output logic [WORD_W-1:0] o_y
);

   localparam int R1 = (WORD_W == 64) ? (SEL ? S1_R1_64 : S0_R1_64)
                                      : (SEL ? S1_R1_32 : S0_R1_32);
   localparam int R2 = (WORD_W == 64) ? (SEL ? S1_R2_64 : S0_R2_64)
                                      : (SEL ? S1_R2_32 : S0_R2_32);
   localparam int SH = (WORD_W == 64) ? (SEL ? S1_SH_64 : S0_SH_64)
                                      : (SEL ? S1_SH_32 : S0_SH_32);

   function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   always_comb begin
      o_y = rotr(i_x, R1) ^ rotr(i_x, R2) ^ (i_x >> SH);
   end

endmodule

// File: rtl/msg_sched.sv
// rtl/msg_sched.sv - SHA-2 message schedule generator, one W[t] word per handshake
// Parameters:
//   WORD_W     32 (SHA-224/256, 64 rounds) or 64 (SHA-384/512, 80 rounds)
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   i_valid    block-load request (honoured in IDLE only)
//   o_ready    high in IDLE, block can be accepted
//   i_block    16-word message block, word 0 in the MSBs
//   i_abort    cancel current block, return to IDLE
//   o_w        current schedule word W[t]
//   o_w_valid  o_w holds a valid word
//   i_w_ready  consumer accepts o_w this cycle
//   o_round    index t of o_w
//   o_last     high with o_w_valid on the final round
module msg_sched
   import msg_sched_pkg::*;
#(
   parameter int WORD_W = 32
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [16*WORD_W-1:0] i_block,
   input  logic                 i_abort,
   output logic [WORD_W-1:0]    o_w,
   output logic                 o_w_valid,
   input  logic                 i_w_ready,
   output logic [6:0]           o_round,
   output logic                 o_last
);

   localparam int         ROUNDS   = rounds_for(WORD_W);
   localparam logic [6:0] LAST_RND = 7'(ROUNDS - 1);

   state_e state_q, state_d;

   // Sliding 16-word window; element 0 is the word currently presented.
   // The [0:15] ordering makes element 0 the MSBs, matching i_block directly.
   logic [0:15][WORD_W-1:0] win_q, win_d;
   logic [6:0]              round_q, round_d;

   logic [WORD_W-1:0] s0_w;
   logic [WORD_W-1:0] s1_w;
   logic [WORD_W-1:0] w_new;

   msg_sigma #(.WORD_W(WORD_W), .SEL(1'b0)) u_sigma0 (
      .i_x (win_q[1]),
      .o_y (s0_w)
   );

   msg_sigma #(.WORD_W(WORD_W), .SEL(1'b1)) u_sigma1 (
      .i_x (win_q[14]),
      .o_y (s1_w)
   );

   // Window positions relative to W[t]: [14]=W[t+14], [9]=W[t+9], [1]=W[t+1].
   assign w_new = s1_w + win_q[9] + s0_w + win_q[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         win_q   <= '0;
         round_q <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         round_q <= round_d;
      end
   end

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      round_d = round_q;
      if (i_abort) begin
         // Abort outranks both load and handshake.
         state_d = IDLE;
         win_d   = '0;
         round_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_valid) begin
                  state_d = RUN;
                  win_d   = i_block;
                  round_d = '0;
               end
            end
            RUN: begin
               if (i_w_ready) begin
                  win_d   = {win_q[1:15], w_new};
                  round_d = (round_q < LAST_RND) ? round_q + 7'd1 : LAST_RND;
                  if (round_q == LAST_RND) begin
                     state_d = IDLE;
                     win_d   = '0;
                     round_d = '0;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               win_d   = '0;
               round_d = '0;
            end
         endcase
      end
   end

   always_comb begin
      o_ready   = 1'b0;
      o_w_valid = 1'b0;
      o_w       = '0;
      o_round   = '0;
      o_last    = 1'b0;
      case (state_q)
         IDLE: begin
            o_ready = 1'b1;
         end
         RUN: begin
            o_w_valid = 1'b1;
            o_w       = win_q[0];
            o_round   = round_q;
            o_last    = (round_q == LAST_RND);
         end
         default: begin
            o_ready = 1'b1;
         end
      endcase
   end

endmodule

// File: doc/msg_sched.md
MSG_SCHED -- requirements
Module: msg_sched

Interface
REQ-001 SHALL have parameter WORD_W, default 32, word width; legal values 32 (SHA-224/256) and 64 (SHA-384/512).
REQ-002 SHALL derive localparam ROUNDS = 64 when WORD_W=32 and 80 when WORD_W=64; not overridable.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port i_valid, input, 1, block-load request.
REQ-006 SHALL have port o_ready, output, 1, high when a block can be accepted.
REQ-007 SHALL have port i_block, input, 16*WORD_W, message block; word 0 in the MSBs.
REQ-008 SHALL have port i_abort, input, 1, cancels the current block.
REQ-009 SHALL have port o_w, output, WORD_W, current schedule word W[t].
REQ-010 SHALL have port o_w_valid, output, 1, o_w holds a valid word.
REQ-011 SHALL have port i_w_ready, input, 1, consumer accepts o_w this cycle.
REQ-012 SHALL have port o_round, output, 7, index t of o_w.
REQ-013 SHALL have port o_last, output, 1, high with o_w_valid when t = ROUNDS-1.

Function
REQ-014 SHALL implement two states: IDLE and RUN.
REQ-015 In IDLE: o_ready=1, o_w_valid=0, o_w=0, o_round=0, o_last=0.
REQ-016 In IDLE, i_valid=1 SHALL load i_block into a 16-word window W[0..15], set o_round=0 and enter RUN on the next cycle.
REQ-017 In RUN: o_ready=0; i_valid ignored; o_w_valid=1; o_w=window[0]; o_round=t.
REQ-018 Output handshake (o_w_valid & i_w_ready) SHALL shift the window down one word, append Wnew and increment o_round.
REQ-019 Wnew SHALL be sigma1(window[14]) + window[9] + sigma0(window[1]) + window[0], computed modulo 2^WORD_W.
REQ-020 For WORD_W=32: sigma0 = ROTR7^ROTR18^SHR3; sigma1 = ROTR17^ROTR19^SHR10.
REQ-021 For WORD_W=64: sigma0 = ROTR1^ROTR8^SHR7; sigma1 = ROTR19^ROTR61^SHR6.
REQ-022 With i_w_ready=0, o_w, o_round, o_last and the window SHALL hold unchanged for any number of cycles.
REQ-023 Handshake with o_last=1 SHALL return to IDLE on the next cycle; the window SHALL clear to 0.
REQ-024 Latency SHALL be: W[0] valid the cycle after load; with i_w_ready held at 1, one word per cycle, ROUNDS cycles total.
REQ-025 i_abort=1 SHALL force IDLE and clear the window next cycle in any state; it takes priority over load and handshake.
REQ-026 Simultaneous i_abort and i_valid in IDLE SHALL NOT load.
REQ-027 Minimum gap between blocks SHALL be one IDLE cycle.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, window=0, o_round=0, o_w_valid=0, o_last=0, o_ready=1 on the next cycle.
REQ-029 rst SHALL take priority over i_abort, load and handshake, including during RUN.

Structure
REQ-030 Package msg_sched_pkg SHALL hold: the state enum {IDLE, RUN}; the rotate/shift constants for both widths; a function returning ROUNDS for a given WORD_W.
REQ-031 The block SHALL contain one combinational sub-module msg_sigma (parameter WORD_W, select sigma0/sigma1), instantiated twice.
REQ-032 The round counter SHALL be 7 bits and SHALL saturate at ROUNDS-1.

Verification
REQ-033 WORD_W=32, block "abc" (W0=0x61626380, W15=0x00000018, rest 0), i_w_ready=1 -> o_w W0..W15 as loaded; W16=0x61626380; W17=0x000F0000; o_last only at o_round=63; o_ready=1 on the following cycle.
REQ-034 WORD_W=64, W0=1, rest 0 -> W16=0x1; W17=0x0; W18=0x0000200000000008; o_last at o_round=79.
REQ-035 WORD_W=32, "abc" block, i_w_ready=0 for 5 cycles at o_round=20 -> o_w and o_round held for 5 cycles; resulting sequence identical to REQ-033.
REQ-036 i_abort pulse at o_round=30 -> IDLE next cycle, o_w_valid=0, o_ready=1; a new load then restarts at o_round=0 with correct W0.
REQ-037 rst pulse at o_round=40 -> all outputs match REQ-028 next cycle; i_valid held during rst -> no load until rst=0.
REQ-038 i_valid held high during RUN -> no reload, sequence unaffected; all-zero block -> every W[t]=0.
